// File: rtl/bcd_display_scanner.sv
`default_nettype none
// ============================================================================
// Module      : bcd_display_scanner
// Description : Sequential double-dabble binary-to-BCD converter feeding a
//               multiplexed common-anode 7-segment scanner with lead blanking.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_display_scanner #(
    parameter int NUM_DIGITS  = 4,
    parameter int BIN_WIDTH   = 14,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_LEAD  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [BIN_WIDTH-1:0]  value,
    input  logic                  load,
    output logic                  busy,
    output logic                  overflow,
    output logic [3:0]            digit,
    output logic [NUM_DIGITS-1:0] anode
);

    // Decimal digits of 2^BIN_WIDTH-1 is floor(BIN_WIDTH*log10(2))+1.
    localparam int c_dig_bin = (BIN_WIDTH * 30103) / 100000 + 1;
    localparam int c_bcd_dig = (c_dig_bin > NUM_DIGITS) ? c_dig_bin : NUM_DIGITS;
    localparam int c_bcd_w   = 4 * c_bcd_dig;
    localparam int c_disp_w  = 4 * NUM_DIGITS;
    localparam int c_cnt_w   = $clog2(BIN_WIDTH + 1);
    localparam int c_ref_w   = $clog2(REFRESH_DIV);
    localparam int c_idx_w   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [c_cnt_w-1:0]    c_cnt_last = c_cnt_w'(BIN_WIDTH - 1);
    localparam logic [c_ref_w-1:0]    c_ref_last = c_ref_w'(REFRESH_DIV - 1);
    localparam logic [c_idx_w-1:0]    c_idx_last = c_idx_w'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] c_one      = NUM_DIGITS'(1);

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_CONVERT = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [BIN_WIDTH-1:0]    r_bin;
    logic [c_bcd_w-1:0]      r_bcd;
    logic [c_cnt_w-1:0]      r_cnt;
    logic [c_disp_w-1:0]     r_disp;
    logic                    r_ovf;
    logic [c_ref_w-1:0]      r_ref;
    logic [c_idx_w-1:0]      r_idx;
    logic [3:0]              r_digit;
    logic [NUM_DIGITS-1:0]   r_anode;

    logic [c_bcd_w-1:0]      w_adj;
    logic [c_bcd_w-1:0]      w_bcd_shift;
    logic                    w_ovf;
    logic                    w_start;
    logic                    w_last;
    logic [c_idx_w-1:0]      w_msnz;
    logic [3:0]              w_nib;

    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < c_bcd_dig; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    assign w_bcd_shift = {w_adj[c_bcd_w-2:0], r_bin[BIN_WIDTH-1]};

    // Any nonzero digit beyond the display width, or a bit lost off the top,
    // means the value cannot be shown.
    generate
        if (c_bcd_dig > NUM_DIGITS) begin : g_ovf_guard
            assign w_ovf = w_adj[c_bcd_w-1] | (|w_bcd_shift[c_bcd_w-1:c_disp_w]);
        end else begin : g_ovf_noguard
            assign w_ovf = w_adj[c_bcd_w-1];
        end
    endgenerate

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (load) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_CONVERT;
                end
            end
            S_CONVERT: begin
                if (r_cnt == c_cnt_last) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin  <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_disp <= '0;
            r_ovf  <= 1'b0;
        end else if (w_start) begin
            r_bin <= value;
            r_bcd <= '0;
            r_cnt <= '0;
        end else if (r_state == S_CONVERT) begin
            r_bin <= r_bin << 1;
            r_bcd <= w_bcd_shift;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
                r_disp <= w_ovf ? {NUM_DIGITS{4'h9}} : w_bcd_shift[c_disp_w-1:0];
                r_ovf  <= w_ovf;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ref <= '0;
            r_idx <= '0;
        end else if (r_ref == c_ref_last) begin
            r_ref <= '0;
            r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
        end else begin
            r_ref <= r_ref + 1'b1;
        end
    end

    // Digit 0 is excluded from the search so an all-zero value still shows "0".
    always_comb begin
        w_msnz = '0;
        w_nib  = r_disp[3:0];
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (r_disp[4*i +: 4] != 4'd0) begin
                w_msnz = c_idx_w'(i);
            end
            if (r_idx == c_idx_w'(i)) begin
                w_nib = r_disp[4*i +: 4];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digit <= 4'hF;
            r_anode <= '1;
        end else begin
            r_anode <= ~(c_one << r_idx);
            r_digit <= ((BLANK_LEAD != 0) && (r_idx > w_msnz)) ? 4'hF : w_nib;
        end
    end

    assign busy     = (r_state == S_CONVERT);
    assign overflow = r_ovf;
    assign digit    = r_digit;
    assign anode    = r_anode;

endmodule
`default_nettype wire

// File: tb/tb_bcd_display_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_display_scanner
// Description : Self-checking bench: vector table, corner sequences, random.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_display_scanner;

    localparam int ND = 4;
    localparam int BW = 14;
    localparam int RD = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load;
    logic [BW-1:0] value;
    logic          busy,  overflow;
    logic [3:0]    digit;
    logic [ND-1:0] anode;
    logic          busy0, overflow0;
    logic [3:0]    digit0;
    logic [ND-1:0] anode0;

    int total = 0;
    int bad   = 0;
    int cyc;

    always #5 clk = ~clk;

    bcd_display_scanner #(.NUM_DIGITS(ND), .BIN_WIDTH(BW), .REFRESH_DIV(RD), .BLANK_LEAD(1)) dut (
        .clk(clk), .rst_n(rst_n), .value(value), .load(load),
        .busy(busy), .overflow(overflow), .digit(digit), .anode(anode)
    );

    bcd_display_scanner #(.NUM_DIGITS(ND), .BIN_WIDTH(BW), .REFRESH_DIV(RD), .BLANK_LEAD(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .value(value), .load(load),
        .busy(busy0), .overflow(overflow0), .digit(digit0), .anode(anode0)
    );

    // Edges since reset release; output after edge k shows scan slot (k-1)/RD.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    typedef struct {
        int          v;
        int          ovf;
        logic [15:0] digs;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model_digs(input int v, input bit bl);
        logic [15:0] r;
        int d, p;
        d = (v > 9999) ? 9999 : v;
        p = 1;
        r = '0;
        for (int i = 0; i < ND; i++) begin
            if (bl && i > 0 && d < p) r[4*i +: 4] = 4'hF;
            else                      r[4*i +: 4] = 4'((d / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic check_display(input logic [15:0] e1, input logic [15:0] e0, input string tag);
        int idx;
        logic [ND-1:0] ea;
        for (int j = 0; j < ND * RD; j++) begin
            @(negedge clk);
            idx = ((cyc - 1) / RD) % ND;
            ea  = ~(ND'(1) << idx);
            chk({tag, "/anode"},  int'(anode),  int'(ea));
            chk({tag, "/digit"},  int'(digit),  int'(e1[4*idx +: 4]));
            chk({tag, "/anode0"}, int'(anode0), int'(ea));
            chk({tag, "/digit0"}, int'(digit0), int'(e0[4*idx +: 4]));
        end
    endtask

    task automatic start_load(input int v);
        @(negedge clk);
        value = BW'(v);
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    task automatic wait_busy(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic convert_and_check(input int v, input int eovf, input logic [15:0] e1, input string tag);
        int n;
        start_load(v);
        wait_busy(n);
        chk({tag, "/busy_len"}, n, BW);
        chk({tag, "/overflow"}, int'(overflow), eovf);
        check_display(e1, model_digs(v, 1'b0), tag);
    endtask

    vec_t vecs[9];

    initial begin
        int n, v;
        vecs[0] = '{v: 1234,  ovf: 0, digs: 16'h1234};
        vecs[1] = '{v: 7,     ovf: 0, digs: 16'hFFF7};
        vecs[2] = '{v: 16383, ovf: 1, digs: 16'h9999};
        vecs[3] = '{v: 42,    ovf: 0, digs: 16'hFF42};
        vecs[4] = '{v: 0,     ovf: 0, digs: 16'hFFF0};
        vecs[5] = '{v: 9999,  ovf: 0, digs: 16'h9999};
        vecs[6] = '{v: 10000, ovf: 1, digs: 16'h9999};
        vecs[7] = '{v: 1000,  ovf: 0, digs: 16'h1000};
        vecs[8] = '{v: 105,   ovf: 0, digs: 16'hF105};

        rst_n = 1'b0;
        load  = 1'b0;
        value = '0;
        repeat (3) @(negedge clk);
        chk("rst/anode", int'(anode), 15);
        chk("rst/digit", int'(digit), 15);
        chk("rst/busy", int'(busy), 0);
        chk("rst/overflow", int'(overflow), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel/anode", int'(anode), 14);
        chk("rel/digit", int'(digit), 0);
        chk("rel/digit0", int'(digit0), 0);

        for (int k = 0; k < 9; k++) begin
            convert_and_check(vecs[k].v, vecs[k].ovf, vecs[k].digs, $sformatf("vec%0d", k));
        end

        // Second load five cycles into a conversion is dropped.
        start_load(4321);
        n = 0;
        while (busy && n < 100) begin
            n++;
            if (n == 5) begin value = BW'(77); load = 1'b1; end
            else        load = 1'b0;
            @(negedge clk);
        end
        load = 1'b0;
        chk("ignore/busy_len", n, BW);
        check_display(16'h4321, model_digs(4321, 1'b0), "ignore");

        // Load on the commit edge is ignored, then accepted one cycle later.
        start_load(812);
        n = 0;
        while (busy && n < 100) begin
            n++;
            if (n == BW) begin value = BW'(3056); load = 1'b1; end
            @(negedge clk);
        end
        chk("commit/busy_len", n, BW);
        chk("commit/busy_low", int'(busy), 0);
        @(negedge clk);
        load = 1'b0;
        chk("commit/accept", int'(busy), 1);
        wait_busy(n);
        chk("commit/busy_len2", n, BW);
        check_display(16'h3056, model_digs(3056, 1'b0), "commit");

        // Reset mid-conversion.
        start_load(5678);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst/busy", int'(busy), 0);
        chk("midrst/anode", int'(anode), 15);
        chk("midrst/digit", int'(digit), 15);
        chk("midrst/overflow", int'(overflow), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst/anode_rel", int'(anode), 14);
        chk("midrst/digit_rel", int'(digit), 0);
        check_display(16'hFFF0, 16'h0000, "midrst_zero");
        convert_and_check(99, 0, 16'hFF99, "after_rst");

        for (int k = 0; k < 12; k++) begin
            v = (k % 2 == 1) ? int'($urandom_range(0, 120)) : int'($urandom_range(0, 16383));
            convert_and_check(v, (v > 9999) ? 1 : 0, model_digs(v, 1'b1), $sformatf("rnd%0d_v%0d", k, v));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
